// File: rtl/div_unit_pkg.sv
// Shared encodings for the execute-stage divider.
// State codes, handshake levels and reset levels.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

endpackage

// File: rtl/div_sign_fix.sv
// Sign handling around the unsigned divider core.
// Absolute values on entry, sign correction on exit.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             sign_en,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] abs_a,
  output logic [WIDTH-1:0] abs_b,
  input  logic             neg_quot,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] quot_raw,
  input  logic [WIDTH-1:0] rem_raw,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  // Most negative value negates to itself, which yields the wrapped quotient.
  always_comb begin
    abs_a = (sign_en && op_a[WIDTH-1]) ? -op_a : op_a;
    abs_b = (sign_en && op_b[WIDTH-1]) ? -op_b : op_b;
    quot  = neg_quot ? -quot_raw : quot_raw;
    rem   = neg_rem ? -rem_raw : rem_raw;
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle, registered outputs.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  div_state_e state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sd_q;
  logic             s1_q;
  logic             s2_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             neg_quot;
  logic             neg_rem;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  // The partial remainder stays below the divisor, so W bits of diff suffice.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - dvs;
    ge      = shifted >= {1'b0, dvs};
    rem_nxt = ge ? diff : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

  // Quotient negates on differing signs; remainder follows the dividend.
  always_comb begin
    neg_quot = sd_q & (s1_q ^ s2_q);
    neg_rem  = sd_q & s1_q;
  end

  div_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .sign_en (signed_div_i),
    .op_a    (opdata1_i),
    .op_b    (opdata2_i),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .neg_quot(neg_quot),
    .neg_rem (neg_rem),
    .quot_raw(quo_nxt),
    .rem_raw (rem_nxt),
    .quot    (quot_fix),
    .rem     (rem_fix)
  );

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      sd_q     <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      unique case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state <= DivOn;
              cnt   <= '0;
              rem   <= '0;
              quo   <= '0;
              dvd   <= abs_a;
              dvs   <= abs_b;
              sd_q  <= signed_div_i;
              s1_q  <= opdata1_i[WIDTH-1];
              s2_q  <= opdata2_i[WIDTH-1];
            end
          end
        end
        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
        DivOn: begin
          ready_o <= DivResultNotReady;
          if (annul_i) begin
            state    <= DivFree;
            result_o <= '0;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            cnt <= cnt + CntOne;
            if (cnt == CntLast) begin
              state    <= DivEnd;
              result_o <= {rem_fix, quot_fix};
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else begin
            ready_o <= DivResultReady;
          end
        end
        default: begin
          state    <= DivFree;
          ready_o  <= DivResultNotReady;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit.
// Hand-computed vectors, immediate assertions.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_chk  = 0;
  int n_fail = 0;

  div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic sd, input logic [31:0] a,
                    input logic [31:0] b);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Next edge is edge 0; report the edge after which ready_o first rose.
  task automatic wait_ready(input string tag, input int exp_edge);
    int edge_idx;
    edge_idx = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ready_o === 1'b1) begin
        edge_idx = i;
        break;
      end
    end
    chk(tag, 64'(edge_idx), 64'(exp_edge));
  endtask

  task automatic drop(input string tag);
    start_i = 1'b0;
    step();
    chk({tag, "_rdy0"}, 64'(ready_o), 64'd0);
    chk({tag, "_res0"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    step();
    step();
    chk("reset_rdy", 64'(ready_o), 64'd0);
    chk("reset_res", result_o, 64'd0);
    rst = 1'b1;
    step();

    go(1'b0, 32'd100, 32'd7);
    wait_ready("u100_7_lat", 33);
    chk("u100_7_res", result_o, 64'h00000002_0000000E);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rdy", 64'(ready_o), 64'd1);
      chk("hold_res", result_o, 64'h00000002_0000000E);
    end
    drop("u100_7");

    go(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_ready("sm7_2_lat", 33);
    chk("sm7_2_res", result_o, 64'hFFFFFFFF_FFFFFFFD);
    drop("sm7_2");

    go(1'b1, 32'd7, 32'hFFFFFFFE);
    wait_ready("s7_m2_lat", 33);
    chk("s7_m2_res", result_o, 64'h00000001_FFFFFFFD);
    drop("s7_m2");

    go(1'b1, 32'h1234, 32'd0);
    wait_ready("dz_lat", 2);
    chk("dz_res", result_o, 64'd0);
    drop("dz");

    go(1'b0, 32'hFFFFFFFF, 32'd1);
    wait_ready("umax_1_lat", 33);
    chk("umax_1_res", result_o, 64'h00000000_FFFFFFFF);
    drop("umax_1");

    go(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready_o !== 1'b0 || result_o !== 64'd0) seen++;
    end
    chk("annul_quiet", 64'(seen), 64'd0);
    go(1'b0, 32'd100, 32'd7);
    wait_ready("post_annul_lat", 33);
    chk("post_annul_res", result_o, 64'h00000002_0000000E);
    drop("post_annul");

    go(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 15; i++) step();
    rst = 1'b0;
    step();
    rst     = 1'b1;
    start_i = 1'b0;
    chk("midrst_rdy", 64'(ready_o), 64'd0);
    chk("midrst_res", result_o, 64'd0);
    go(1'b0, 32'd1000, 32'd10);
    annul_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready_o !== 1'b0 || result_o !== 64'd0) seen++;
    end
    chk("start_annul_quiet", 64'(seen), 64'd0);
    annul_i = 1'b0;
    wait_ready("u1000_10_lat", 33);
    chk("u1000_10_res", result_o, 64'h00000000_00000064);
    drop("u1000_10");

    go(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_ready("ovf_lat", 33);
    chk("ovf_res", result_o, 64'h00000000_80000000);
    drop("ovf");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
